pmem_responder: RTL
===================

# pmem_responder

Synthesizable physical-memory responder answering the cache's pmem-side line requests. It serves the `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `pmem_rdata` and `pmem_resp` handshake with a programmable fixed latency. It backs a small line-granular array and pairs with the cache in simulation and FPGA bring-up as its lower-level memory.

## Interface
- `LINE_W`, default 256: line width in bits; must be a power of two ≥ 8.
- `ADDR_W`, default 32: address width.
- `IDX_W`, default 4: line-index bits; the array holds 2^IDX_W lines.
- `LATENCY`, default 4: cycles from request sample to `pmem_resp`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  line read request, level, held until resp.
- `pmem_write`  in  1  line write request, level, held until resp.
- `pmem_address`  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored.
- `pmem_wdata`  in  LINE_W  write line data.
- `pmem_rdata`  out  LINE_W  read line data, valid while `pmem_resp`=1.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- Index = `pmem_address[OFF+IDX_W-1:OFF]`, where OFF = log2(LINE_W/8). Higher address bits are ignored, so addresses alias modulo 2^IDX_W lines.
- FSM states: IDLE, BUSY, RESP, GAP.
- IDLE:
  - If `pmem_read` or `pmem_write` is high, latch op, index and `pmem_wdata`.
  - Load the latency counter with LATENCY-1.
  - Go to RESP if LATENCY=1, else BUSY.
- BUSY:
  - Decrement the counter.
  - At count 1, go to RESP.
  - Input changes are ignored; latched values are used.
- RESP:
  - Assert `pmem_resp` for this cycle only.
  - Read: drive `pmem_rdata` = array[latched index].
  - Write: commit the latched wdata to array[latched index] on this cycle's edge.
  - Go to GAP.
- GAP: one idle cycle during which requests are ignored, so a request still held high on the cycle after resp is not re-accepted. Then go to IDLE.
- `pmem_read` and `pmem_write` both high when sampled in IDLE: perform the write, ignore the read, set `proto_err`.
- Request dropped (both inputs low) during BUSY: the transaction still completes and responds; set `proto_err`.
- `pmem_rdata` holds its last value outside RESP; after a write response it is unchanged.
- `proto_err` is cleared only by reset.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE, counter 0.
  - `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0.
  - All array lines cleared to 0.
- Reset asserted mid-transaction aborts it; a pending write is not committed.
- Request sampled in IDLE at edge N gives `pmem_resp` high during cycle N+LATENCY (the cycle after edge N+LATENCY-1).
- Throughput: one transaction per LATENCY+2 cycles with back-to-back requests.
- A read of a line written by the immediately preceding transaction returns the new data; the write commits before GAP.
- A read-after-write to the same index is never stale.
- No combinational path from inputs to `pmem_resp` or `pmem_rdata`; both are registered or driven from registered state.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles, then release -> `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0. A read of 0x0000_0040 returns 0.
- **Write then read:**
  - Write 0xDEAD…BEEF (256 bits) to 0x0000_0060 with LATENCY=4 -> resp exactly 4 cycles after the sample edge, lasting 1 cycle.
  - Read of 0x0000_0060 issued 1 cycle after GAP -> same data, resp 4 cycles later.
- **Aliasing:** write line A to 0x0000_0020, then read 0x0000_0220 with IDX_W=4 -> returns A (index 1 in both).
- **Held request after resp:** keep `pmem_read` high 1 cycle past resp, then drop it -> exactly one resp pulse and no second transaction.
- **Protocol errors:**
  - Assert read and write together to 0x40 with data 0x5A… -> write performed, `proto_err`=1.
  - After reset, drop `pmem_read` in BUSY -> resp still issued, `proto_err`=1.
- **Mid-transaction reset:** pull `rst` low during BUSY of a write of 0xFF… to 0x80, then release and read 0x80 -> returns 0, and no resp occurs before the new read completes.

Source files
------------

// File: rtl/pmem_responder_if.sv
// Line-request handshake between a cache (master) and its backing memory (slave).
interface pmem_responder_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
);
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp
   );

   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp
   );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency line memory answering cache pmem requests.
// A request is latched in IDLE, aged in BUSY, answered with a one-cycle
// resp pulse in RESP, and followed by a GAP cycle so a request still held
// high right after resp is not taken as a second transaction.
module pmem_responder #(
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int IDX_W   = 4,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   pmem_responder_if.slave   bus,
   output logic              proto_err
);

   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int DEPTH = 1 << IDX_W;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              resp_q, resp_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              mem_we;
   logic [LINE_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]  req_idx;
   logic              req_any;
   logic              unused_addr;

   // Only the index field of the address selects a line; the rest aliases.
   assign req_idx     = bus.pmem_address[OFF+IDX_W-1:OFF];
   assign req_any     = bus.pmem_read | bus.pmem_write;
   assign unused_addr = ^bus.pmem_address;

   // Next-state logic; read data is fetched on the way into RESP so rdata is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      resp_d  = 1'b0;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               op_wr_d = bus.pmem_write;
               idx_d   = req_idx;
               wdata_d = bus.pmem_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (bus.pmem_read && bus.pmem_write) begin
                  err_d = 1'b1;
               end
               if (LATENCY == 1) begin
                  state_d = RESP;
                  resp_d  = 1'b1;
                  if (!bus.pmem_write) begin
                     rdata_d = mem_q[req_idx];
                  end
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!req_any) begin
               err_d = 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               resp_d  = 1'b1;
               if (!op_wr_q) begin
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         RESP: begin
            mem_we  = op_wr_q;
            state_d = GAP;
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         resp_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Line array; a write lands on the RESP edge so a following read sees it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign bus.pmem_resp  = resp_q;
   assign bus.pmem_rdata = rdata_q;
   assign proto_err      = err_q;

endmodule
